// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: request sequencer between the pipeline memory stage and the
// 2-way cache memory system. One load/store is accepted at a time, the
// request is held stable on the mem_* side until Done (or a timeout), and a
// registered one-cycle response pulse is returned to the pipeline.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   req_*             pipeline request (valid, rd, wr, addr, wdata)
//   req_ready         high in IDLE: a request is accepted this cycle
//   pipe_stall        req_valid & ~req_ready
//   rsp_*             response pulse, read data, hit flag, error flag
//   mem_Addr/DataIn/Rd/Wr     held request toward the memory system
//   mem_DataOut/Done/CacheHit/err  completion from the memory system
//   mem_Stall         informational only, not used
//
// Parameters
//   TIMEOUT      ISSUE cycles without Done before abort (1..255)
//   CHECK_ALIGN  1: odd byte addresses are rejected as illegal
//
// Build option MEM_REQ_PERF_CNT_EN adds saturating perf_access, perf_hit and
// perf_err counters.
module mem_req_ctrl #(
  parameter int TIMEOUT     = 63,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        pipe_stall,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_hit,
  output logic        rsp_err,
  output logic [15:0] mem_Addr,
  output logic [15:0] mem_DataIn,
  output logic        mem_Rd,
  output logic        mem_Wr,
  input  logic [15:0] mem_DataOut,
  input  logic        mem_Done,
  input  logic        mem_Stall,
  input  logic        mem_CacheHit,
  input  logic        mem_err
`ifdef MEM_REQ_PERF_CNT_EN
  ,
  output logic [15:0] perf_access,
  output logic [15:0] perf_hit,
  output logic [15:0] perf_err
`endif
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  state_t      r_state;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_rd;
  logic        r_wr;
  logic [7:0]  r_cnt;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_rdata;
  logic        r_rsp_hit;
  logic        r_rsp_err;

  logic        w_misalign;
  logic        w_legal;
  logic [7:0]  w_cnt_nxt;
  logic        w_timeout;
  logic        w_unused;

  assign w_misalign = CHECK_ALIGN & req_addr[0];
  assign w_legal    = (req_rd ^ req_wr) & ~w_misalign;
  assign w_cnt_nxt  = r_cnt + 8'd1;
  // count holds the number of completed Done-less ISSUE cycles, so the op is
  // visible for exactly TIMEOUT cycles before the abort
  assign w_timeout  = (w_cnt_nxt == LP_TIMEOUT);
  assign w_unused   = mem_Stall;

  assign req_ready  = (r_state == IDLE);
  assign pipe_stall = req_valid & ~req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_hit    = r_rsp_hit;
  assign rsp_err    = r_rsp_err;
  // r_rd/r_wr are only set while in ISSUE, so they drive the memory directly
  assign mem_Rd     = r_rd;
  assign mem_Wr     = r_wr;
  assign mem_Addr   = r_addr;
  assign mem_DataIn = r_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_legal) begin
              r_addr  <= req_addr;
              r_wdata <= req_wdata;
              r_rd    <= req_rd;
              r_wr    <= req_wr;
              r_cnt   <= '0;
              r_state <= ISSUE;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_hit   <= 1'b0;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Done takes priority over a timeout landing in the same cycle
          if (mem_Done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_rd ? mem_DataOut : 16'h0000;
            r_rsp_hit   <= mem_CacheHit;
            r_rsp_err   <= mem_err;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_state     <= IDLE;
          end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_REQ_PERF_CNT_EN
  logic w_acc_evt;
  logic w_hit_evt;
  logic w_err_evt;

  assign w_acc_evt = (r_state == ISSUE) & mem_Done;
  assign w_hit_evt = w_acc_evt & mem_CacheHit;
  assign w_err_evt = ((r_state == IDLE) & req_valid & ~w_legal) |
                     ((r_state == ISSUE) & (mem_Done ? mem_err : w_timeout));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_access <= '0;
      perf_hit    <= '0;
      perf_err    <= '0;
    end else begin
      if (w_acc_evt && perf_access != 16'hFFFF) perf_access <= perf_access + 16'd1;
      if (w_hit_evt && perf_hit    != 16'hFFFF) perf_hit    <= perf_hit + 16'd1;
      if (w_err_evt && perf_err    != 16'hFFFF) perf_err    <= perf_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl. Two instances share the stimulus:
// d0 uses the default TIMEOUT, d1 uses TIMEOUT=8 for the abort cases.
// Inputs change on the falling edge; outputs are checked there too.
module tb_mem_req_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid, req_rd, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic [15:0] mem_DataOut;
  logic        mem_Done, mem_Stall, mem_CacheHit, mem_err;

  logic        d0_ready, d0_stall, d0_rv, d0_hit, d0_err, d0_rd, d0_wr;
  logic [15:0] d0_rdata, d0_addr, d0_din;
  logic        d1_ready, d1_stall, d1_rv, d1_hit, d1_err, d1_rd, d1_wr;
  logic [15:0] d1_rdata, d1_addr, d1_din;
`ifdef MEM_REQ_PERF_CNT_EN
  logic [15:0] d0_pacc, d0_phit, d0_perr, d1_pacc, d1_phit, d1_perr;
`endif

  int nvec = 0;
  int nerr = 0;

  mem_req_ctrl u_d0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(d0_ready), .pipe_stall(d0_stall),
    .rsp_valid(d0_rv), .rsp_rdata(d0_rdata), .rsp_hit(d0_hit), .rsp_err(d0_err),
    .mem_Addr(d0_addr), .mem_DataIn(d0_din), .mem_Rd(d0_rd), .mem_Wr(d0_wr),
    .mem_DataOut(mem_DataOut), .mem_Done(mem_Done), .mem_Stall(mem_Stall),
    .mem_CacheHit(mem_CacheHit), .mem_err(mem_err)
`ifdef MEM_REQ_PERF_CNT_EN
    , .perf_access(d0_pacc), .perf_hit(d0_phit), .perf_err(d0_perr)
`endif
  );

  mem_req_ctrl #(.TIMEOUT(8)) u_d1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(d1_ready), .pipe_stall(d1_stall),
    .rsp_valid(d1_rv), .rsp_rdata(d1_rdata), .rsp_hit(d1_hit), .rsp_err(d1_err),
    .mem_Addr(d1_addr), .mem_DataIn(d1_din), .mem_Rd(d1_rd), .mem_Wr(d1_wr),
    .mem_DataOut(mem_DataOut), .mem_Done(mem_Done), .mem_Stall(mem_Stall),
    .mem_CacheHit(mem_CacheHit), .mem_err(mem_err)
`ifdef MEM_REQ_PERF_CNT_EN
    , .perf_access(d1_pacc), .perf_hit(d1_phit), .perf_err(d1_perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] wd);
    req_valid = v; req_rd = rd; req_wr = wr; req_addr = a; req_wdata = wd;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    mem_DataOut = 16'h0; mem_Done = 1'b0; mem_Stall = 1'b0;
    mem_CacheHit = 1'b0; mem_err = 1'b0;

    // reset state
    #2;
    chk("rst_ready", d0_ready, 1'b1);
    chk("rst_rd", d0_rd, 1'b0);
    chk("rst_wr", d0_wr, 1'b0);
    chk("rst_addr", d0_addr, 16'h0);
    chk("rst_din", d0_din, 16'h0);
    chk("rst_rv", d0_rv, 1'b0);
    chk("rst_rdata", d0_rdata, 16'h0);
    chk("rst_hit", d0_hit, 1'b0);
    chk("rst_err", d0_err, 1'b0);
    chk("rst_stall", d0_stall, 1'b0);
    @(negedge clk); rst = 1'b1;

    // 1: read hit, Done in first ISSUE cycle
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0);
    #1 chk("t1_ready", d0_ready, 1'b1);
    chk("t1_stall0", d0_stall, 1'b0);
    @(negedge clk);
    chk("t1_rd", d0_rd, 1'b1);
    chk("t1_addr", d0_addr, 16'h0010);
    chk("t1_busy", d0_ready, 1'b0);
    chk("t1_rv_early", d0_rv, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    mem_Done = 1'b1; mem_DataOut = 16'hBEEF; mem_CacheHit = 1'b1;
    @(negedge clk);
    mem_Done = 1'b0; mem_CacheHit = 1'b0; mem_DataOut = 16'h0;
    chk("t1_rv", d0_rv, 1'b1);
    chk("t1_rdata", d0_rdata, 16'hBEEF);
    chk("t1_hit", d0_hit, 1'b1);
    chk("t1_err", d0_err, 1'b0);
    chk("t1_rd_off", d0_rd, 1'b0);
    chk("t1_ready_back", d0_ready, 1'b1);
    @(negedge clk);
    chk("t1_rv_pulse", d0_rv, 1'b0);
    chk("t1_rdata_hold", d0_rdata, 16'hBEEF);

    // 2: write, Done in 12th ISSUE cycle; request inputs ignored meanwhile
    drive(1'b1, 1'b0, 1'b1, 16'h0A40, 16'h1234);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("t2_wr", d0_wr, 1'b1);
      chk("t2_rd", d0_rd, 1'b0);
      chk("t2_addr", d0_addr, 16'h0A40);
      chk("t2_din", d0_din, 16'h1234);
      drive(1'b1, 1'b1, 1'b0, 16'h0003, 16'hFFFF);
      if (i == 12) begin
        mem_Done = 1'b1; mem_CacheHit = 1'b0; mem_DataOut = 16'h5555;
      end
      #1 chk("t2_stall", d0_stall, 1'b1);
    end
    @(negedge clk);
    mem_Done = 1'b0; mem_DataOut = 16'h0;
    chk("t2_rv", d0_rv, 1'b1);
    chk("t2_hit", d0_hit, 1'b0);
    chk("t2_err", d0_err, 1'b0);
    chk("t2_rdata", d0_rdata, 16'h0000);
    chk("t2_wr_off", d0_wr, 1'b0);

    // 3: illegal requests (misaligned, rd&wr)
    drive(1'b1, 1'b1, 1'b0, 16'h0013, 16'h0);
    #1 chk("t3_stall", d0_stall, 1'b0);
    @(negedge clk);
    chk("t3a_rv", d0_rv, 1'b1);
    chk("t3a_err", d0_err, 1'b1);
    chk("t3a_rdata", d0_rdata, 16'h0);
    chk("t3a_hit", d0_hit, 1'b0);
    chk("t3a_rd", d0_rd, 1'b0);
    chk("t3a_ready", d0_ready, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 16'h0020, 16'h0);
    @(negedge clk);
    chk("t3b_rv", d0_rv, 1'b1);
    chk("t3b_err", d0_err, 1'b1);
    chk("t3b_rd", d0_rd, 1'b0);
    chk("t3b_wr", d0_wr, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("t3_rv_off", d0_rv, 1'b0);
    chk("t3_ready", d1_ready, 1'b1);

    // 4: timeout on d1 (TIMEOUT=8), then immediate new accept
    drive(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      chk("t4_rd_on", d1_rd, 1'b1);
      chk("t4_rv_quiet", d1_rv, 1'b0);
    end
    @(negedge clk);
    chk("t4_rd_off", d1_rd, 1'b0);
    chk("t4_rv", d1_rv, 1'b1);
    chk("t4_err", d1_err, 1'b1);
    chk("t4_hit", d1_hit, 1'b0);
    chk("t4_ready", d1_ready, 1'b1);
    chk("t4_d0_still", d0_rd, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0);
    @(negedge clk);
    chk("t4_reacc", d1_rd, 1'b1);
    chk("t4_reacc_addr", d1_addr, 16'h0200);
    chk("t4_d0_hold", d0_addr, 16'h0100);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    mem_Done = 1'b1; mem_DataOut = 16'h00AA; mem_CacheHit = 1'b1;
    @(negedge clk);
    mem_Done = 1'b0; mem_DataOut = 16'h0; mem_CacheHit = 1'b0;
    chk("t4_d0_rv", d0_rv, 1'b1);
    chk("t4_d0_rdata", d0_rdata, 16'h00AA);
    chk("t4_d1_rdata", d1_rdata, 16'h00AA);
    chk("t4_d1_err", d1_err, 1'b0);

    // 4b: back-to-back accept in response cycle; Done on the timeout cycle wins
    drive(1'b1, 1'b1, 1'b0, 16'h0400, 16'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      chk("t4b_rd", d1_rd, 1'b1);
      chk("t4b_addr", d0_addr, 16'h0400);
      if (i == 8) begin
        mem_Done = 1'b1; mem_DataOut = 16'h0F0F; mem_CacheHit = 1'b1;
      end
    end
    @(negedge clk);
    mem_Done = 1'b0; mem_DataOut = 16'h0; mem_CacheHit = 1'b0;
    chk("t4b_rv", d1_rv, 1'b1);
    chk("t4b_err", d1_err, 1'b0);
    chk("t4b_rdata", d1_rdata, 16'h0F0F);
    chk("t4b_hit", d1_hit, 1'b1);

    // 4c: memory error on Done
    drive(1'b1, 1'b1, 1'b0, 16'h0500, 16'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    mem_Done = 1'b1; mem_err = 1'b1; mem_DataOut = 16'h7777;
    @(negedge clk);
    mem_Done = 1'b0; mem_err = 1'b0; mem_DataOut = 16'h0;
    chk("t4c_rv", d0_rv, 1'b1);
    chk("t4c_err", d0_err, 1'b1);
    chk("t4c_rdata", d0_rdata, 16'h7777);

    // 5: asynchronous reset mid-ISSUE
    drive(1'b1, 1'b1, 1'b0, 16'h0300, 16'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("t5_rd_on", d0_rd, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t5_rd_async", d0_rd, 1'b0);
    chk("t5_ready_async", d0_ready, 1'b1);
    chk("t5_rdata_clr", d0_rdata, 16'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("t5_rd", d0_rd, 1'b1);
    mem_Done = 1'b1; mem_DataOut = 16'h1357;
    @(negedge clk);
    mem_Done = 1'b0; mem_DataOut = 16'h0;
    chk("t5_rv", d0_rv, 1'b1);
    chk("t5_rdata", d0_rdata, 16'h1357);
    chk("t5_err", d0_err, 1'b0);

`ifdef MEM_REQ_PERF_CNT_EN
    // 6: 3 hits, 1 miss, 1 misaligned
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      mem_Done = 1'b1; mem_CacheHit = (i != 3);
      @(negedge clk);
      mem_Done = 1'b0; mem_CacheHit = 1'b0;
    end
    drive(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk("t6_access", d0_pacc, 16'd4);
    chk("t6_hit", d0_phit, 16'd3);
    chk("t6_err", d0_perr, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Pipeline-side request sequencer that sits directly upstream of the 2-way cache memory system (mem_system); one instance per memory port.
- Accepts a single load/store from the memory stage and holds Addr/DataIn/Rd/Wr stable until the memory system signals Done.
- Returns a registered response (read data, hit flag, error) to the pipeline.
- Screens illegal requests (misaligned, Rd&Wr together) and aborts hung accesses with a timeout.

Parameters:
TIMEOUT, 63, maximum cycles in ISSUE before abort; legal range 1..255.
CHECK_ALIGN, 1, when 1 odd byte addresses are rejected; when 0 addr[0] passes through unchanged.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-low
req_valid  input  1  pipeline request present
req_rd  input  1  load request
req_wr  input  1  store request
req_addr  input  16  byte address
req_wdata  input  16  store data
req_ready  output  1  controller can accept a request this cycle
pipe_stall  output  1  memory stage must hold
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  16  load data; valid with rsp_valid
rsp_hit  output  1  CacheHit captured with Done
rsp_err  output  1  response is an error (illegal, timeout or memory err)
mem_Addr  output  16  to memory system Addr
mem_DataIn  output  16  to memory system DataIn
mem_Rd  output  1  to memory system Rd
mem_Wr  output  1  to memory system Wr
mem_DataOut  input  16  from memory system DataOut
mem_Done  input  1  from memory system Done
mem_Stall  input  1  from memory system Stall (informational only)
mem_CacheHit  input  1  from memory system CacheHit
mem_err  input  1  from memory system err

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is asynchronous and active-low on rst.
  - rst low forces state IDLE immediately, without waiting for clk.
- Reset values:
  - All registers clear on reset: latched address, write data and op bits, timeout count, response registers.
  - Output values while rst is low: mem_Rd=0, mem_Wr=0, mem_Addr=0, mem_DataIn=0, rsp_valid=0, rsp_rdata=0, rsp_hit=0, rsp_err=0, req_ready=1, pipe_stall=0.
- States:
  - IDLE: req_ready=1, mem_Rd/mem_Wr=0.
  - ISSUE: req_ready=0, mem_Rd/mem_Wr driven from latched op, mem_Addr/mem_DataIn from latched regs.
- pipe_stall = req_valid & ~req_ready (combinational).
- IDLE, req_valid=1 with exactly one of req_rd/req_wr, and aligned (addr[0]=0, or CHECK_ALIGN=0):
  - Latch addr, wdata and op; clear timeout count; go to ISSUE.
- IDLE, req_valid=1 with an illegal request (rd=wr, or misaligned with CHECK_ALIGN=1):
  - No memory access; stay in IDLE.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0, rsp_hit=0.
- ISSUE, mem_Done=1:
  - Capture mem_DataOut (loads; 0 for stores), mem_CacheHit and mem_err into the response regs; go to IDLE.
  - Next cycle: rsp_valid=1, rsp_err=mem_err.
  - mem_Done in the first ISSUE cycle is legal (cache hit): accept-to-rsp_valid latency is 2 cycles minimum.
- ISSUE, no mem_Done: increment the 8-bit count.
  - When count reaches TIMEOUT: drop mem_Rd/mem_Wr, go to IDLE.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_hit=0.
  - mem_Done in the same cycle as the timeout wins: normal completion.
- Holding rules:
  - mem_Addr, mem_DataIn and the op are stable for the whole of ISSUE; request inputs are ignored while in ISSUE.
  - mem_Stall is not used for control.
- Back-to-back: rsp_valid and req_ready=1 coincide in the IDLE cycle after Done, so a new request may be accepted in that same cycle.
- rsp_valid is exactly one cycle; all response outputs hold their values until the next response.

Optional Feature:
- Macro: MEM_REQ_PERF_CNT_EN.
- Defined: adds outputs perf_access[15:0], perf_hit[15:0] and perf_err[15:0].
  - perf_access counts completed ISSUE accesses.
  - perf_hit counts completed accesses with CacheHit=1.
  - perf_err counts rsp_err responses.
  - All three are saturating at 0xFFFF and cleared by rst.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Read addr 0x0010; memory model asserts Done in the first ISSUE cycle with DataOut=0xBEEF, CacheHit=1 -> mem_Rd high 1 cycle; rsp_valid 2 cycles after accept; rsp_rdata=0xBEEF, rsp_hit=1, rsp_err=0.
2. Write 0x1234 to 0x0A40; Done after 12 cycles, CacheHit=0 -> mem_Wr/mem_Addr/mem_DataIn stable for 12 cycles; pipe_stall high for any req_valid during that time; rsp_valid the cycle after Done with rsp_hit=0.
3. Read 0x0013 with CHECK_ALIGN=1; also rd=wr=1 at 0x0020 -> mem_Rd/mem_Wr never assert; rsp_valid=1 and rsp_err=1 the next cycle, rsp_rdata=0.
4. TIMEOUT=8, read with Done never asserted -> mem_Rd high exactly 8 cycles then low; rsp_err=1 next cycle; new request accepted immediately after.
5. rst driven low mid-ISSUE, between clock edges -> mem_Rd drops to 0 without a clock edge, req_ready=1; first access after reset completes normally.
6. With MEM_REQ_PERF_CNT_EN: 3 hits, 1 miss, 1 misaligned request -> perf_access=4, perf_hit=3, perf_err=1.
